// File: rtl/reg_pipe_skid.sv
// reg_pipe_skid: single-stage valid/ready pipeline register with a one-entry
// skid buffer. All outputs (o_valid, o_ready, o_data) come straight from flops,
// so neither the forward data/valid path nor the backward ready path passes
// combinationally through this stage. Order is preserved and no beat is ever
// dropped or duplicated.
module reg_pipe_skid #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RSTN_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    // EMPTY: nothing held; BUSY: main register holds the oldest beat;
    // FULL: main holds the oldest beat and skid holds the next one.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  ready_q;
    logic                  ready_d;

    logic                  in_fire_s;
    logic                  out_fire_s;

    // Handshake events, evaluated against the registered ready/valid flags.
    always_comb begin
        in_fire_s  = i_valid & ready_q;
        out_fire_s = valid_q & i_ready;
    end

    // State and data registers; synchronous active-low reset discards all beats.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= RSTN_VALUE;
            skid_q  <= RSTN_VALUE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and data-capture logic; flush overrides every other event.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
            main_d  = RSTN_VALUE;
            skid_d  = RSTN_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d = ST_BUSY;
                        main_d  = i_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d = ST_BUSY;
                        main_d  = i_data;
                    end else if (in_fire_s) begin
                        // Downstream stalled: park the new beat behind the old one.
                        state_d = ST_FULL;
                        skid_d  = i_data;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // o_ready is low here, so no capture can happen.
                    if (out_fire_s) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = RSTN_VALUE;
                    skid_d  = RSTN_VALUE;
                end
            endcase
        end
    end

    // Output flags derived from the next state so they can be registered.
    always_comb begin
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_FULL);
    end

    // Drive ports directly from the flops.
    always_comb begin
        o_valid = valid_q;
        o_ready = ready_q;
        o_data  = main_q;
    end

endmodule

// File: tb/tb_reg_pipe_skid.sv
// Testbench for reg_pipe_skid: directed scenarios plus a random stream, with a
// scoreboard queue filled on input acceptance and drained by an output monitor.
module tb_reg_pipe_skid;

    localparam int          DW   = 32;
    localparam logic [31:0] RSTV = 32'hDEAD;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;

    int            errors;
    int            checks;
    logic [DW-1:0] exp_q[$];
    logic          stall_prev;
    logic [DW-1:0] data_prev;
    logic          done;

    reg_pipe_skid #(.DATA_WIDTH(DW), .RSTN_VALUE(RSTV)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Input side: push accepted beats as expected outputs; reset/flush clears.
    initial begin
        stall_prev = 1'b0;
        data_prev  = 32'h0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n || i_flush) begin
                exp_q.delete();
            end else if (i_valid && o_ready) begin
                exp_q.push_back(i_data);
            end
        end
    end

    // Output side: compare each delivered beat and check stall stability.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst_n && !i_flush) begin
                if (stall_prev) begin
                    chk("stall_valid", {31'b0, o_valid}, 32'h1);
                    chk("stall_data", o_data, data_prev);
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", o_data, 32'hFFFF_FFFF ^ o_data);
                    end else begin
                        chk("beat", o_data, exp_q.pop_front());
                    end
                end
            end
            stall_prev = o_valid & ~i_ready & i_rst_n & ~i_flush;
            data_prev  = o_data;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        done = 1'b0;
        #2000000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: got running expected finished");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        logic acc;
        errors  = 0;
        checks  = 0;
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 32'h0;

        // 1. Reset held two cycles.
        step();
        step();
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_ready", {31'b0, o_ready}, 32'h1);
        chk("rst_data", o_data, 32'hDEAD);
        i_rst_n = 1'b1;
        step();

        // 2. Streaming 1..8 with one-cycle latency.
        i_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1'b1;
            i_data  = k;
            step();
            chk("stream_valid", {31'b0, o_valid}, 32'h1);
            chk("stream_data", o_data, k);
            chk("stream_ready", {31'b0, o_ready}, 32'h1);
        end
        i_valid = 1'b0;
        step();
        chk("stream_drained", {31'b0, o_valid}, 32'h0);

        // 3. Backpressure into FULL, then release.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hA;
        step();
        chk("bp_busy_data", o_data, 32'hA);
        chk("bp_busy_ready", {31'b0, o_ready}, 32'h1);
        i_data = 32'hB;
        step();
        chk("bp_full_ready", {31'b0, o_ready}, 32'h0);
        chk("bp_full_data", o_data, 32'hA);
        i_data = 32'h77;
        step();
        chk("bp_hold_ready", {31'b0, o_ready}, 32'h0);
        chk("bp_hold_data", o_data, 32'hA);
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        chk("bp_second_data", o_data, 32'hB);
        chk("bp_ready_back", {31'b0, o_ready}, 32'h1);
        step();
        chk("bp_empty", {31'b0, o_valid}, 32'h0);

        // 4. Flush from FULL with a same-cycle offered beat.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hA;
        step();
        i_data = 32'hB;
        step();
        chk("fl_full_ready", {31'b0, o_ready}, 32'h0);
        i_flush = 1'b1;
        i_data  = 32'hC;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("fl_valid", {31'b0, o_valid}, 32'h0);
        chk("fl_ready", {31'b0, o_ready}, 32'h1);
        chk("fl_data", o_data, 32'hDEAD);
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_nothing", {31'b0, o_valid}, 32'h0);
        end

        // 5. Reset while BUSY.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h5;
        step();
        chk("mr_busy_data", o_data, 32'h5);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        chk("mr_valid", {31'b0, o_valid}, 32'h0);
        chk("mr_ready", {31'b0, o_ready}, 32'h1);
        chk("mr_data", o_data, 32'hDEAD);
        i_ready = 1'b1;
        step();
        chk("mr_nothing", {31'b0, o_valid}, 32'h0);

        // 6. Random traffic; upstream holds a beat until it is accepted.
        acc = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!(i_valid && !acc)) begin
                i_valid = 1'($urandom_range(0, 1));
                i_data  = $urandom;
            end
            i_ready = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            acc = i_valid & o_ready;
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
        end
        chk("rand_drained", {31'b0, o_valid}, 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
